mbox_fifo_ctrl: RTL and testbench
=================================

# mbox_fifo_ctrl

Multi-CPU mailbox front end arbitrating per-CPU register requests onto a shared outbound AXI-Stream FIFO port (writes) and an inbound AXI-Stream FIFO port (reads). Successor to the single-requester FIFO controller: N request channels, round-robin arbitration, a real valid/ready handshake with bounded-wait timeout, a read path, and configurable ACK pulse length. Sits between the CPU bus decoders and the mailbox message FIFOs.

## Interface
- W_WIDTH_SYS, 32, data word width
- WIDTH_ADDR, 32, address width
- N_NUMB_CPU, 4, number of requesting CPUs (1..16)
- W_ID, derived: N_NUMB_CPU>1 ? $clog2(N_NUMB_CPU) : 1, CPU index width
- FIFO_DATA, derived: W_ID+WIDTH_ADDR+W_WIDTH_SYS, outbound word width
- ACK_HOLD, 4, cycles ack is held high (1..255)
- TIMEOUT, 16, max cycles waiting for s_tready_i/m_tvalid_i; 0 = wait forever

- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- req_i  in  N_NUMB_CPU  per-CPU request level
- wren_i  in  N_NUMB_CPU  per-CPU 1=write, 0=read
- addr_i  in  N_NUMB_CPU*WIDTH_ADDR  packed addresses, CPU k at slice k
- data_i  in  N_NUMB_CPU*W_WIDTH_SYS  packed write data
- rdata_o  out  W_WIDTH_SYS  read data, valid while ack_o[grant]=1
- ack_o  out  N_NUMB_CPU  one-hot completion
- err_full_o  out  1  write timed out, high with ack
- err_empty_o  out  1  read timed out, high with ack
- busy_o  out  1  high whenever state != IDLE
- s_tdata_o  out  FIFO_DATA  {cpu_id, addr, data}
- s_tvalid_o  out  1  outbound valid
- s_tready_i  in  1  outbound ready
- m_tdata_i  in  W_WIDTH_SYS  inbound data
- m_tvalid_i  in  1  inbound valid
- m_tready_o  out  1  inbound pop, single-cycle pulse

## Operation
- States: IDLE, WR, RD, ACK, REL. Unknown encoding -> IDLE.
- IDLE: if req_i != 0, pick grant g (arbitration below), latch g, wren_i[g], addr, data; go WR (write) or RD (read).
- WR: s_tvalid_o=1, s_tdata_o={g, addr, data} stable. Transfer on s_tvalid_o && s_tready_i -> drop valid, go ACK. Timeout -> drop valid, err_full_o=1, go ACK.
- RD: on m_tvalid_i, capture m_tdata_i into rdata_o, pulse m_tready_o one cycle, go ACK. Timeout -> rdata_o=0, err_empty_o=1, go ACK.
- ACK: ack_o[g]=1 for exactly ACK_HOLD cycles, then ack_o=0, err flags cleared, go REL.
- REL: wait until req_i[g]=0, then IDLE. Prevents double-issue from held requests.
- Timeout counter: 8-bit, cleared on entry to WR/RD, increments each waiting cycle; fires when count reaches TIMEOUT-1. TIMEOUT=0 disables.
- Arbitration: round-robin; priority starts at CPU (last_g+1) mod N, last_g resets to N-1 (CPU 0 first after reset).

## Timing
- Reset: all outputs 0, state IDLE, counters 0, last_g=N-1.
- Cycle 0 request seen in IDLE; cycle 1 s_tvalid_o=1 (WR) or m_tvalid_i sampled (RD).
- Write with s_tready_i=1: transfer cycle 1, ack_o high cycles 2..2+ACK_HOLD-1.
- Read with m_tvalid_i=1: m_tready_o pulses cycle 1, rdata_o/ack_o from cycle 2.
- s_tvalid_o never drops before handshake or timeout; s_tdata_o stable while valid.
- Requests arriving in non-IDLE states wait; requester deasserting before grant is simply not served.
- Reset mid-transfer aborts immediately; s_tvalid_o and ack_o low next cycle.
- At most one err flag high at a time; never high outside ACK.

## Configuration
- MBOX_RR_ARB_EN defined: round-robin arbitration as above.
- Undefined: fixed priority, lowest-index active req_i wins; last_g unused and optimised away.

## Test plan
- Single write: CPU2 req, wren=1, addr=0x10, data=0xA5A5A5A5, s_tready=1 -> s_tdata_o={2,0x10,0xA5A5A5A5} cycle 1, ack_o=4'b0100 for 4 cycles, err_full_o=0.
- Backpressure: s_tready=0 for 5 cycles then 1 -> s_tvalid_o held 6 cycles, data stable, single transfer, no error.
- Full timeout: s_tready=0 forever, TIMEOUT=16 -> s_tvalid_o drops after 16 cycles, err_full_o=1 with ack, then both 0; CPU release returns IDLE.
- Read: CPU1 wren=0, m_tvalid=1, m_tdata=0x1234 -> m_tready_o one pulse, rdata_o=0x1234 with ack_o=4'b0010; empty case -> err_empty_o=1, rdata_o=0.
- Round-robin: all four req_i held, each released after ack -> grant order 0,1,2,3,0; with macro undefined order 0,0 while CPU0 re-requests.
- Reset during WR wait -> s_tvalid_o, ack_o, busy_o 0 next cycle; next request served as CPU0 first.

Source files
------------

// File: rtl/mbox_fifo_ctrl.sv
// mbox_fifo_ctrl: multi-CPU mailbox front end. Arbitrates per-CPU requests onto an outbound
// AXI-Stream write port and an inbound read port. Define MBOX_RR_ARB_EN for round-robin, else fixed priority.
module mbox_fifo_ctrl #(
  parameter  int W_WIDTH_SYS = 32,
  parameter  int WIDTH_ADDR  = 32,
  parameter  int N_NUMB_CPU  = 4,
  parameter  int ACK_HOLD    = 4,
  parameter  int TIMEOUT     = 16,
  localparam int W_ID        = (N_NUMB_CPU > 1) ? $clog2(N_NUMB_CPU) : 1,
  localparam int FIFO_DATA   = W_ID + WIDTH_ADDR + W_WIDTH_SYS
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [N_NUMB_CPU-1:0]             req_i,
  input  logic [N_NUMB_CPU-1:0]             wren_i,
  input  logic [N_NUMB_CPU*WIDTH_ADDR-1:0]  addr_i,
  input  logic [N_NUMB_CPU*W_WIDTH_SYS-1:0] data_i,
  output logic [W_WIDTH_SYS-1:0]            rdata_o,
  output logic [N_NUMB_CPU-1:0]             ack_o,
  output logic                              err_full_o,
  output logic                              err_empty_o,
  output logic                              busy_o,
  output logic [FIFO_DATA-1:0]              s_tdata_o,
  output logic                              s_tvalid_o,
  input  logic                              s_tready_i,
  input  logic [W_WIDTH_SYS-1:0]            m_tdata_i,
  input  logic                              m_tvalid_i,
  output logic                              m_tready_o
);

  // state | meaning
  // IDLE  | no transaction, arbitrating over req_i
  // WR    | s_tvalid_o high, waiting for s_tready_i or timeout
  // RD    | waiting for m_tvalid_i or timeout
  // ACK   | ack_o[g] (and any error flag) held for ACK_HOLD cycles
  // REL   | waiting for the served CPU to drop its request
  typedef enum logic [2:0] {IDLE, WR, RD, ACK, REL} state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(ACK_HOLD - 1);

  state_t                  state;
  logic [W_ID-1:0]         g;
  logic [W_ID-1:0]         pick;
  logic [N_NUMB_CPU-1:0]   pick_oh;
  logic [N_NUMB_CPU-1:0]   g_oh;
  logic                    pick_wr;
  logic [WIDTH_ADDR-1:0]   pick_addr;
  logic [W_WIDTH_SYS-1:0]  pick_data;
  logic [WIDTH_ADDR-1:0]   addr_q;
  logic [W_WIDTH_SYS-1:0]  data_q;
  logic [7:0]              tmo_cnt;
  logic [7:0]              hold_cnt;
  logic                    tmo_fire;

`ifdef MBOX_RR_ARB_EN
  logic [W_ID-1:0]         last_g;
  logic                    rr_found;

  // Scan starting one past the last grant; the inner loop keeps every index constant.
  always_comb begin
    pick     = '0;
    rr_found = 1'b0;
    for (int i = 0; i < N_NUMB_CPU; i++) begin
      for (int k = 0; k < N_NUMB_CPU; k++) begin
        if (!rr_found && req_i[k] && (((int'(last_g) + 1 + i) % N_NUMB_CPU) == k)) begin
          pick     = W_ID'(k);
          rr_found = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    pick = '0;
    for (int k = N_NUMB_CPU - 1; k >= 0; k--) begin
      if (req_i[k]) pick = W_ID'(k);
    end
  end
`endif

  always_comb begin
    pick_oh   = '0;
    g_oh      = '0;
    pick_addr = '0;
    pick_data = '0;
    for (int k = 0; k < N_NUMB_CPU; k++) begin
      pick_oh[k] = (int'(pick) == k);
      g_oh[k]    = (int'(g) == k);
      if (int'(pick) == k) begin
        pick_addr = addr_i[k*WIDTH_ADDR +: WIDTH_ADDR];
        pick_data = data_i[k*W_WIDTH_SYS +: W_WIDTH_SYS];
      end
    end
  end

  assign pick_wr    = |(wren_i & pick_oh);
  assign tmo_fire   = (TIMEOUT != 0) && (tmo_cnt == 8'(TIMEOUT - 1));
  assign s_tdata_o  = {g, addr_q, data_q};
  // Pop in the same cycle the word is seen; ready may depend on valid.
  assign m_tready_o = (state == RD) && m_tvalid_i;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      g           <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      tmo_cnt     <= '0;
      hold_cnt    <= '0;
      rdata_o     <= '0;
      ack_o       <= '0;
      err_full_o  <= 1'b0;
      err_empty_o <= 1'b0;
      busy_o      <= 1'b0;
      s_tvalid_o  <= 1'b0;
`ifdef MBOX_RR_ARB_EN
      last_g      <= W_ID'(N_NUMB_CPU - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req_i) begin
            g       <= pick;
            addr_q  <= pick_addr;
            data_q  <= pick_data;
            tmo_cnt <= '0;
            busy_o  <= 1'b1;
`ifdef MBOX_RR_ARB_EN
            last_g  <= pick;
`endif
            if (pick_wr) begin
              state      <= WR;
              s_tvalid_o <= 1'b1;
            end else begin
              state <= RD;
            end
          end
        end

        WR: begin
          if (s_tready_i) begin
            s_tvalid_o <= 1'b0;
            ack_o      <= g_oh;
            hold_cnt   <= HOLD_LOAD;
            state      <= ACK;
          end else if (tmo_fire) begin
            s_tvalid_o <= 1'b0;
            err_full_o <= 1'b1;
            ack_o      <= g_oh;
            hold_cnt   <= HOLD_LOAD;
            state      <= ACK;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        RD: begin
          if (m_tvalid_i) begin
            rdata_o  <= m_tdata_i;
            ack_o    <= g_oh;
            hold_cnt <= HOLD_LOAD;
            state    <= ACK;
          end else if (tmo_fire) begin
            rdata_o     <= '0;
            err_empty_o <= 1'b1;
            ack_o       <= g_oh;
            hold_cnt    <= HOLD_LOAD;
            state       <= ACK;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        ACK: begin
          if (hold_cnt == 8'd0) begin
            ack_o       <= '0;
            err_full_o  <= 1'b0;
            err_empty_o <= 1'b0;
            rdata_o     <= '0;
            state       <= REL;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end

        REL: begin
          if (!(|(req_i & g_oh))) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          s_tvalid_o  <= 1'b0;
          ack_o       <= '0;
          err_full_o  <= 1'b0;
          err_empty_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbox_fifo_ctrl.sv
// tb_mbox_fifo_ctrl: directed and randomized checks of mbox_fifo_ctrl against a transaction-level model.
// Arbitration expectations follow MBOX_RR_ARB_EN the same way the design does.
module tb_mbox_fifo_ctrl;
  localparam int WS  = 32;
  localparam int WA  = 32;
  localparam int N   = 4;
  localparam int AH  = 4;
  localparam int TO  = 16;
  localparam int WID = 2;
  localparam int FD  = WID + WA + WS;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   req_i, wren_i;
  logic [N*WA-1:0] addr_i;
  logic [N*WS-1:0] data_i;
  logic [WS-1:0]  rdata_o;
  logic [N-1:0]   ack_o;
  logic           err_full_o, err_empty_o, busy_o;
  logic [FD-1:0]  s_tdata_o;
  logic           s_tvalid_o, s_tready_i;
  logic [WS-1:0]  m_tdata_i;
  logic           m_tvalid_i, m_tready_o;

  logic [WA-1:0]  a_arr [N];
  logic [WS-1:0]  d_arr [N];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_last;

  // measurements of the last transaction
  int            m_grant, m_ack_cycles, m_ack_start, m_tv_cycles, m_pops, m_pop_cycle;
  logic [N-1:0]  m_ack_val;
  logic          m_ack_bad, m_tdata_bad, m_errf, m_erre, m_err_bad, m_hung;
  logic [FD-1:0] m_tdata;
  logic [WS-1:0] m_rdata;

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign addr_i[k*WA +: WA] = a_arr[k];
    assign data_i[k*WS +: WS] = d_arr[k];
  end

  mbox_fifo_ctrl #(
    .W_WIDTH_SYS (WS),
    .WIDTH_ADDR  (WA),
    .N_NUMB_CPU  (N),
    .ACK_HOLD    (AH),
    .TIMEOUT     (TO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_i       (req_i),
    .wren_i      (wren_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .rdata_o     (rdata_o),
    .ack_o       (ack_o),
    .err_full_o  (err_full_o),
    .err_empty_o (err_empty_o),
    .busy_o      (busy_o),
    .s_tdata_o   (s_tdata_o),
    .s_tvalid_o  (s_tvalid_o),
    .s_tready_i  (s_tready_i),
    .m_tdata_i   (m_tdata_i),
    .m_tvalid_i  (m_tvalid_i),
    .m_tready_o  (m_tready_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic [N-1:0] mask, input int last);
    logic [WID-1:0] jj;
`ifdef MBOX_RR_ARB_EN
    for (int i = 1; i <= N; i++) begin
      jj = WID'((last + i) % N);
      if (mask[jj]) return (last + i) % N;
    end
`else
    for (int i = 0; i < N; i++) begin
      jj = WID'(i);
      if (mask[jj]) return i;
    end
`endif
    return -1;
  endfunction

  // Drives one request round from IDLE: ready/valid rise after `delay` low cycles in WR/RD.
  // Releases only the served CPU afterwards and returns in the following IDLE cycle.
  task automatic run_txn(input logic [N-1:0] mask, input logic [N-1:0] wr, input int delay,
                         input logic [WS-1:0] word);
    int   cyc;
    logic ack_seen;
    m_ack_cycles = 0; m_ack_start = -1; m_tv_cycles = 0; m_pops = 0; m_pop_cycle = -1;
    m_ack_val = '0; m_ack_bad = 0; m_tdata_bad = 0; m_errf = 0; m_erre = 0; m_err_bad = 0;
    m_tdata = '0; m_rdata = '0; m_hung = 1; ack_seen = 0;
    req_i = mask; wren_i = wr; s_tready_i = 0; m_tvalid_i = 0; m_tdata_i = word;
    cyc = 0;
    while (cyc < 300) begin
      tick;
      cyc++;
      s_tready_i = (cyc > delay);
      m_tvalid_i = (cyc > delay);
      #1;
      if (s_tvalid_o) begin
        m_tv_cycles++;
        if (m_tv_cycles == 1) m_tdata = s_tdata_o;
        else if (s_tdata_o !== m_tdata) m_tdata_bad = 1;
      end
      if (m_tready_o) begin
        m_pops++;
        m_pop_cycle = cyc;
      end
      if ((err_full_o || err_empty_o) && ack_o == '0) m_err_bad = 1;
      if (err_full_o && err_empty_o) m_err_bad = 1;
      if (ack_o != '0) begin
        m_ack_cycles++;
        if (!ack_seen) begin
          ack_seen = 1; m_ack_start = cyc; m_ack_val = ack_o;
          m_rdata = rdata_o; m_errf = err_full_o; m_erre = err_empty_o;
        end else if (ack_o !== m_ack_val || rdata_o !== m_rdata ||
                     err_full_o !== m_errf || err_empty_o !== m_erre) begin
          m_ack_bad = 1;
        end
      end else if (ack_seen) begin
        m_hung = 0;
        break;
      end
    end
    m_grant = -1;
    for (int k = 0; k < N; k++) if (m_ack_val == (N'(1) << k)) m_grant = k;
    req_i = mask & ~m_ack_val;
    s_tready_i = 0; m_tvalid_i = 0;
    cyc = 0;
    while (busy_o && cyc < 20) begin
      tick;
      cyc++;
    end
    if (busy_o) m_hung = 1;
  endtask

  task automatic test_reset;
    rstn = 0; req_i = '0; wren_i = '0; s_tready_i = 0; m_tvalid_i = 0; m_tdata_i = '0;
    for (int k = 0; k < N; k++) begin a_arr[WID'(k)] = '0; d_arr[WID'(k)] = '0; end
    tick; tick;
    n_tests++; if (ack_o !== '0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", ack_o); end
    n_tests++; if (busy_o !== 1'b0 || s_tvalid_o !== 1'b0 || m_tready_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_ctrl: busy %b tvalid %b tready %b want 0", busy_o, s_tvalid_o, m_tready_o); end
    n_tests++; if (err_full_o !== 1'b0 || err_empty_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_err: full %b empty %b want 0", err_full_o, err_empty_o); end
    n_tests++; if (rdata_o !== '0 || s_tdata_o !== '0) begin
      n_fail++; $display("FAIL rst_data: rdata %h tdata %h want 0", rdata_o, s_tdata_o); end
    rstn = 1;
    exp_last = N - 1;
    tick;
    n_tests++; if (busy_o !== 1'b0 || ack_o !== '0) begin
      n_fail++; $display("FAIL rst_idle: busy %b ack %b want 0", busy_o, ack_o); end
  endtask

  task automatic test_single_write;
    logic [FD-1:0] exp_td;
    a_arr[2] = 32'h10; d_arr[2] = 32'hA5A5_A5A5;
    exp_td = {2'd2, 32'h10, 32'hA5A5_A5A5};
    run_txn(4'b0100, 4'b0100, 0, '0);
    n_tests++; if (m_hung) begin n_fail++; $display("FAIL sw_done: got hung want complete"); end
    n_tests++; if (m_tdata !== exp_td || m_tv_cycles != 1) begin
      n_fail++; $display("FAIL sw_tdata: got %h x%0d want %h x1", m_tdata, m_tv_cycles, exp_td); end
    n_tests++; if (m_ack_val !== 4'b0100 || m_ack_start != 2 || m_ack_cycles != AH) begin
      n_fail++; $display("FAIL sw_ack: got %b at %0d for %0d want 0100 at 2 for %0d",
                         m_ack_val, m_ack_start, m_ack_cycles, AH); end
    n_tests++; if (m_errf !== 1'b0 || m_err_bad) begin
      n_fail++; $display("FAIL sw_err: got full %b bad %b want 0", m_errf, m_err_bad); end
    exp_last = 2;
  endtask

  task automatic test_backpressure;
    a_arr[3] = 32'hBEEF_0004; d_arr[3] = 32'h0BAD_F00D;
    run_txn(4'b1000, 4'b1000, 5, '0);
    n_tests++; if (m_tv_cycles != 6 || m_tdata_bad) begin
      n_fail++; $display("FAIL bp_valid: got %0d cycles unstable %b want 6 stable", m_tv_cycles, m_tdata_bad); end
    n_tests++; if (m_tdata !== {2'd3, 32'hBEEF_0004, 32'h0BAD_F00D}) begin
      n_fail++; $display("FAIL bp_tdata: got %h", m_tdata); end
    n_tests++; if (m_ack_start != 7 || m_ack_cycles != AH || m_errf !== 1'b0 || m_ack_bad) begin
      n_fail++; $display("FAIL bp_ack: got start %0d len %0d err %b want 7 %0d 0", m_ack_start, m_ack_cycles, m_errf, AH); end
    exp_last = 3;
  endtask

  task automatic test_full_timeout;
    a_arr[1] = 32'h44; d_arr[1] = 32'h5555_AAAA;
    run_txn(4'b0010, 4'b0010, 1000, '0);
    n_tests++; if (m_tv_cycles != TO) begin
      n_fail++; $display("FAIL to_valid: got %0d cycles want %0d", m_tv_cycles, TO); end
    n_tests++; if (m_errf !== 1'b1 || m_erre !== 1'b0 || m_ack_val !== 4'b0010 || m_ack_start != TO + 1) begin
      n_fail++; $display("FAIL to_err: got full %b empty %b ack %b at %0d want 1 0 0010 at %0d",
                         m_errf, m_erre, m_ack_val, m_ack_start, TO + 1); end
    n_tests++; if (m_err_bad || m_hung || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL to_release: got errbad %b hung %b busy %b want 0", m_err_bad, m_hung, busy_o); end
    exp_last = 1;
  endtask

  task automatic test_read;
    run_txn(4'b0010, 4'b0000, 0, 32'h1234);
    n_tests++; if (m_pops != 1 || m_pop_cycle != 1 || m_tv_cycles != 0) begin
      n_fail++; $display("FAIL rd_pop: got %0d pops at %0d tvalid %0d want 1 at 1, 0", m_pops, m_pop_cycle, m_tv_cycles); end
    n_tests++; if (m_rdata !== 32'h1234 || m_ack_val !== 4'b0010 || m_ack_start != 2 || m_erre !== 1'b0) begin
      n_fail++; $display("FAIL rd_data: got %h ack %b at %0d empty %b want 1234 0010 at 2 0",
                         m_rdata, m_ack_val, m_ack_start, m_erre); end
    run_txn(4'b0010, 4'b0000, 1000, 32'hDEAD);
    n_tests++; if (m_pops != 0 || m_erre !== 1'b1 || m_errf !== 1'b0 || m_rdata !== '0) begin
      n_fail++; $display("FAIL rd_empty: got pops %0d empty %b full %b rdata %h want 0 1 0 0",
                         m_pops, m_erre, m_errf, m_rdata); end
    n_tests++; if (m_ack_start != TO + 1 || m_ack_cycles != AH || m_err_bad) begin
      n_fail++; $display("FAIL rd_empty_ack: got %0d len %0d want %0d len %0d", m_ack_start, m_ack_cycles, TO + 1, AH); end
    exp_last = 1;
  endtask

  task automatic test_hold_release;
    int cyc;
    a_arr[0] = 32'h7; d_arr[0] = 32'h77;
    req_i = 4'b0001; wren_i = 4'b0001; s_tready_i = 1;
    cyc = 0;
    while (ack_o == '0 && cyc < 50) begin tick; cyc++; end
    while (ack_o != '0 && cyc < 50) begin tick; cyc++; end
    n_tests++; if (cyc >= 50) begin n_fail++; $display("FAIL hold_wait: got no ack cycle want ack"); end
    for (int i = 0; i < 5; i++) begin
      tick;
      n_tests++; if (busy_o !== 1'b1 || s_tvalid_o !== 1'b0 || ack_o !== '0) begin
        n_fail++; $display("FAIL hold_rel: got busy %b tvalid %b ack %b want 1 0 0", busy_o, s_tvalid_o, ack_o); end
    end
    req_i = '0; s_tready_i = 0;
    tick;
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL hold_idle: got busy %b want 0", busy_o); end
    exp_last = 0;
  endtask

  task automatic test_arbitration;
    int exp_g;
    rstn = 0; req_i = '0; tick; rstn = 1; exp_last = N - 1;
    for (int k = 0; k < N; k++) begin a_arr[WID'(k)] = WA'(k); d_arr[WID'(k)] = WS'(k * 16); end
    for (int t = 0; t < 5; t++) begin
      exp_g = model_pick(4'b1111, exp_last);
      run_txn(4'b1111, 4'b1111, 0, '0);
      n_tests++; if (m_grant != exp_g || m_hung) begin
        n_fail++; $display("FAIL arb_order[%0d]: got %0d want %0d", t, m_grant, exp_g); end
      exp_last = exp_g;
    end
    req_i = '0; tick;
  endtask

  task automatic test_reset_mid_wr;
    int exp_g;
    a_arr[2] = 32'h22; d_arr[2] = 32'h2222;
    req_i = 4'b0100; wren_i = 4'b0100; s_tready_i = 0;
    tick; tick; tick;
    n_tests++; if (s_tvalid_o !== 1'b1) begin n_fail++; $display("FAIL rmw_wait: got tvalid %b want 1", s_tvalid_o); end
    rstn = 0;
    tick;
    n_tests++; if (s_tvalid_o !== 1'b0 || ack_o !== '0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL rmw_abort: got tvalid %b ack %b busy %b want 0", s_tvalid_o, ack_o, busy_o); end
    rstn = 1; req_i = '0; exp_last = N - 1;
    tick;
    exp_g = model_pick(4'b1111, exp_last);
    run_txn(4'b1111, 4'b1111, 0, '0);
    n_tests++; if (m_grant != exp_g) begin n_fail++; $display("FAIL rmw_first: got %0d want %0d", m_grant, exp_g); end
    exp_last = exp_g;
    req_i = '0; tick;
  endtask

  task automatic test_random;
    logic [N-1:0]  mask, wr;
    logic [WS-1:0] word;
    logic [FD-1:0] exp_td;
    int delay, exp_g, exp_xfer;
    logic exp_err, exp_wr;
    for (int t = 0; t < 40; t++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      wr   = N'($urandom);
      word = $urandom;
      for (int k = 0; k < N; k++) begin a_arr[WID'(k)] = $urandom; d_arr[WID'(k)] = $urandom; end
      delay = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 8);
      exp_g    = model_pick(mask, exp_last);
      exp_wr   = wr[WID'(exp_g)];
      exp_err  = (delay >= TO);
      exp_xfer = exp_err ? TO : delay + 1;
      exp_td   = {WID'(exp_g), a_arr[WID'(exp_g)], d_arr[WID'(exp_g)]};
      run_txn(mask, wr, delay, word);
      n_tests++; if (m_grant != exp_g || m_hung) begin
        n_fail++; $display("FAIL rnd_grant[%0d]: got %0d hung %b want %0d", t, m_grant, m_hung, exp_g); end
      n_tests++; if (m_ack_start != exp_xfer + 1 || m_ack_cycles != AH || m_ack_bad || m_err_bad) begin
        n_fail++; $display("FAIL rnd_ack[%0d]: got start %0d len %0d want %0d len %0d",
                           t, m_ack_start, m_ack_cycles, exp_xfer + 1, AH); end
      if (exp_wr) begin
        n_tests++; if (m_tv_cycles != exp_xfer || m_tdata !== exp_td || m_tdata_bad || m_pops != 0) begin
          n_fail++; $display("FAIL rnd_wr[%0d]: got %0d cycles %h want %0d cycles %h", t, m_tv_cycles, m_tdata, exp_xfer, exp_td); end
        n_tests++; if (m_errf !== exp_err || m_erre !== 1'b0) begin
          n_fail++; $display("FAIL rnd_wr_err[%0d]: got full %b empty %b want %b 0", t, m_errf, m_erre, exp_err); end
      end else begin
        n_tests++; if (m_pops != (exp_err ? 0 : 1) || m_tv_cycles != 0 || m_rdata !== (exp_err ? '0 : word)) begin
          n_fail++; $display("FAIL rnd_rd[%0d]: got pops %0d rdata %h want %0d %h",
                             t, m_pops, m_rdata, exp_err ? 0 : 1, exp_err ? '0 : word); end
        n_tests++; if (m_erre !== exp_err || m_errf !== 1'b0) begin
          n_fail++; $display("FAIL rnd_rd_err[%0d]: got empty %b full %b want %b 0", t, m_erre, m_errf, exp_err); end
      end
      exp_last = exp_g;
    end
    req_i = '0; tick;
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_backpressure;
    test_full_timeout;
    test_read;
    test_hold_release;
    test_arbitration;
    test_reset_mid_wr;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
